// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: parity-mode
// encodings, receiver FSM states and the 3-sample majority vote.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2,
        S_BREAK
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_baud_gen.sv
// Sample-tick generator: down-counter reloaded with i_div, one-cycle tick
// at terminal count, so ticks are i_div+1 clocks apart. i_restart reloads
// the counter so the tick phase is aligned to the detected start edge.
module uart_rx_baud_gen #(
    parameter int DIV_W = 12
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_restart,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;
    logic             w_tc;

    assign w_tc   = (r_cnt == '0);
    assign o_tick = w_tc & ~i_restart;

    // Free-running down-counter with reload at terminal count or restart
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_restart || w_tc) begin
            r_cnt <= i_div;
        end else begin
            r_cnt <= r_cnt - DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with oversampling, majority vote, optional
// parity, 1/2 stop bits and a one-word valid/ready holding register.
// Optional feature macro: UART_RX_BREAK_DET_EN (adds break_det output and
// suppresses all-zero frames instead of delivering them as framing errors).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | line idle, waiting for synchronised 1->0 edge
// S_START  | validating start bit at mid-bit (high majority = glitch)
// S_DATA   | sampling DATA_W data bits, LSB first
// S_PARITY | sampling parity bit (even/odd modes only)
// S_STOP1  | sampling first stop bit
// S_STOP2  | sampling second stop bit (stop2 latched high)
// S_BREAK  | break seen, waiting for one full bit time of line high
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OVS    = 16,
    parameter int DIV_W  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_in,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic [1:0]        parity_mode,
    input  logic              stop2,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
`ifdef UART_RX_BREAK_DET_EN
    ,
    output logic              break_det
`endif
);

    localparam int IDX_W = $clog2(OVS);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam int BRK_W = IDX_W + 1;

    // Tick index 1 is the first tick after the start edge, so the three
    // votes straddle the middle of every bit.
    localparam logic [IDX_W-1:0] IDX_S0   = IDX_W'(OVS / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_S1   = IDX_W'(OVS / 2);
    localparam logic [IDX_W-1:0] IDX_S2   = IDX_W'(OVS / 2 + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OVS - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BRK_W-1:0] BRK_FULL = BRK_W'(OVS);

    rx_state_t          r_state;
    rx_state_t          w_state_nxt;

    logic               r_sync1;
    logic               r_sync2;
    logic               r_rx_prev;
    logic               w_rx;
    logic               w_start_edge;

    logic [DIV_W-1:0]   r_baud_div;
    logic [1:0]         r_par_mode;
    logic               r_stop2;
    logic [DIV_W-1:0]   w_div;

    logic               w_tick;
    logic [IDX_W-1:0]   r_idx;
    logic               r_s0;
    logic               r_s1;
    logic               w_mid;
    logic               w_maj;

    logic [DATA_W-1:0]  r_shift;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic               r_par_bit;
    logic               r_stop_low;
    logic [BRK_W-1:0]   r_brk_cnt;

    logic               w_par_en;
    logic               w_par_err;
    logic               w_frm_err;
    logic               w_final;
    logic               w_brk_frame;

    logic               w_restart;
    logic               w_load;
    logic               w_brk_set;

    logic [DATA_W-1:0]  r_rx_data;
    logic               r_rx_valid;
    logic               r_parity_err;
    logic               r_frame_err;
    logic               r_overrun;

    assign w_rx         = r_sync2;
    assign w_start_edge = r_rx_prev & ~w_rx;

    // Two-flop synchroniser plus one delay stage for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rx_in;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    // Frame configuration snapshot taken at the start edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_baud_div <= '0;
            r_par_mode <= PAR_NONE;
            r_stop2    <= 1'b0;
        end else if (w_restart) begin
            r_baud_div <= baud_div;
            r_par_mode <= parity_mode;
            r_stop2    <= stop2;
        end
    end

    // Live divisor while idle so the restart load uses the new value
    assign w_div = (r_state == S_IDLE) ? baud_div : r_baud_div;

    uart_rx_baud_gen #(
        .DIV_W (DIV_W)
    ) u_baud_gen (
        .i_clk     (clk),
        .i_rst_n   (reset),
        .i_restart (w_restart),
        .i_div     (w_div),
        .o_tick    (w_tick)
    );

    // Tick position within the current bit and the two early votes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx <= '0;
            r_s0  <= 1'b1;
            r_s1  <= 1'b1;
        end else if (w_restart) begin
            r_idx <= IDX_W'(1);
        end else if (w_tick) begin
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
            if (r_idx == IDX_S0) r_s0 <= w_rx;
            if (r_idx == IDX_S1) r_s1 <= w_rx;
        end
    end

    assign w_mid    = w_tick && (r_idx == IDX_S2);
    assign w_maj    = majority3(r_s0, r_s1, w_rx);

    assign w_par_en  = (r_par_mode == PAR_EVEN) || (r_par_mode == PAR_ODD);
    assign w_par_err = w_par_en & ((^{r_shift, r_par_bit}) ^ (r_par_mode == PAR_ODD));
    assign w_frm_err = r_stop_low | ~w_maj;
    assign w_final   = w_mid && (((r_state == S_STOP1) && !r_stop2) || (r_state == S_STOP2));

`ifdef UART_RX_BREAK_DET_EN
    assign w_brk_frame = (r_shift == '0) && !(w_par_en && r_par_bit) && !w_maj &&
                         !(r_stop2 && !r_stop_low);
`else
    assign w_brk_frame = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-frame strobes
    always_comb begin
        w_state_nxt = r_state;
        w_restart   = 1'b0;
        w_load      = 1'b0;
        w_brk_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_edge) begin
                    w_restart   = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_mid) w_state_nxt = w_maj ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_mid && (r_bit_cnt == BIT_LAST))
                    w_state_nxt = w_par_en ? S_PARITY : S_STOP1;
            end
            S_PARITY: begin
                if (w_mid) w_state_nxt = S_STOP1;
            end
            S_STOP1, S_STOP2: begin
                if (w_final) begin
                    if (w_brk_frame) begin
                        w_brk_set   = 1'b1;
                        w_state_nxt = S_BREAK;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else if (w_mid) begin
                    w_state_nxt = S_STOP2;
                end
            end
            S_BREAK: begin
                if (r_brk_cnt == BRK_FULL) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Frame datapath: data shifter, bit count, parity and stop samples
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_par_bit  <= 1'b0;
            r_stop_low <= 1'b0;
        end else if (w_restart) begin
            r_bit_cnt  <= '0;
            r_par_bit  <= 1'b0;
            r_stop_low <= 1'b0;
        end else if (w_mid) begin
            case (r_state)
                S_DATA: begin
                    r_shift   <= {w_maj, r_shift[DATA_W-1:1]};
                    r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                end
                S_PARITY: r_par_bit  <= w_maj;
                S_STOP1:  r_stop_low <= ~w_maj;
                default:  ;
            endcase
        end
    end

    // Consecutive high ticks while recovering from a break
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_brk_cnt <= '0;
        end else if (r_state != S_BREAK) begin
            r_brk_cnt <= '0;
        end else if (w_tick) begin
            if (!w_rx) begin
                r_brk_cnt <= '0;
            end else if (r_brk_cnt != BRK_FULL) begin
                r_brk_cnt <= r_brk_cnt + BRK_W'(1);
            end
        end
    end

    // Holding register: load, drop-on-full with overrun, handshake release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_load && !(r_rx_valid && !rx_ready)) begin
                r_rx_data    <= r_shift;
                r_parity_err <= w_par_err;
                r_frame_err  <= w_frm_err;
                r_rx_valid   <= 1'b1;
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid   <= 1'b0;
            end

            if (w_load && r_rx_valid && !rx_ready) begin
                r_overrun <= 1'b1;
            end else if (r_rx_valid && rx_ready) begin
                r_overrun <= 1'b0;
            end
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    logic r_break_det;

    // One-clock break indication
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_break_det <= 1'b0;
        end else begin
            r_break_det <= w_brk_set;
        end
    end

    assign break_det = r_break_det;
`endif

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: OVS=16, baud_div=3 (64 clk/bit).
// Expected words are queued as frames are driven and compared on handshake.
module tb_uart_rx_param;

    localparam int DATA_W   = 8;
    localparam int OVS      = 16;
    localparam int DIV_W    = 12;
    localparam int BIT_CLKS = 64;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic              clk;
    logic              reset;
    logic              rx_in;
    logic [DIV_W-1:0]  baud_div;
    logic [1:0]        parity_mode;
    logic              stop2;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              parity_err;
    logic              frame_err;
    logic              overrun;
    logic              busy;
`ifdef UART_RX_BREAK_DET_EN
    logic              break_det;
`endif

    exp_t q[$];
    exp_t mon_e;
    int   n_vec;
    int   n_err;
    int   lat_cyc;

    uart_rx_param #(
        .DATA_W (DATA_W),
        .OVS    (OVS),
        .DIV_W  (DIV_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_in       (rx_in),
        .baud_div    (baud_div),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .busy        (busy)
`ifdef UART_RX_BREAK_DET_EN
        ,
        .break_det   (break_det)
`endif
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx_in = b;
        repeat (BIT_CLKS) @(posedge clk);
    endtask

    task automatic idle_bits(input int n);
        rx_in = 1'b1;
        repeat (n * BIT_CLKS) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input bit bad_par,
                              input bit s1_low, input bit two_stop, input bit s2_low,
                              input bit push);
        logic pb;
        exp_t e;
        parity_mode = pm;
        stop2       = two_stop;
        e.d  = d;
        e.pe = bad_par && (pm == 2'b01 || pm == 2'b10);
        e.fe = s1_low || (two_stop && s2_low);
        if (push) q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (pm == 2'b01 || pm == 2'b10) begin
            pb = (pm == 2'b01) ? (^d) : ~(^d);
            drive_bit(pb ^ bad_par);
        end
        drive_bit(~s1_low);
        if (two_stop) drive_bit(~s2_low);
        rx_in = 1'b1;
    endtask

    task automatic wait_drain();
        int cyc;
        cyc = 0;
        while (q.size() != 0 && cyc < 3000) begin
            @(posedge clk);
            cyc++;
        end
        check("drain_pending", q.size(), 0);
    endtask

    // Scoreboard: compare each consumed word against the oldest expectation
    always @(negedge clk) begin
        if (reset && rx_valid && rx_ready) begin
            if (q.size() == 0) begin
                check("unexpected_word", {24'h0, rx_data}, 32'hFFFF_FFFF);
            end else begin
                mon_e = q.pop_front();
                check("word_data", rx_data, mon_e.d);
                check("word_perr", parity_err, mon_e.pe);
                check("word_ferr", frame_err, mon_e.fe);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit push_zero;
        n_vec       = 0;
        n_err       = 0;
        reset       = 1'b0;
        rx_in       = 1'b1;
        baud_div    = DIV_W'(3);
        parity_mode = 2'b00;
        stop2       = 1'b0;
        rx_ready    = 1'b1;

        #1;
        check("rst_valid", rx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_data", rx_data, 0);
        check("rst_perr", parity_err, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_overrun", overrun, 0);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        idle_bits(2);

        // Basic frame and load latency measured from the start-bit fall
        fork
            send_frame(8'h55, 2'b00, 0, 0, 0, 0, 1);
            begin
                lat_cyc = 0;
                while (!rx_valid && lat_cyc < 1000) begin
                    @(posedge clk);
                    #1;
                    lat_cyc++;
                end
            end
        join
        check("lat_55_window", (lat_cyc >= 596 && lat_cyc <= 636), 1);
        idle_bits(2);
        wait_drain();

        send_frame(8'hA3, 2'b01, 1, 0, 0, 0, 1);
        idle_bits(2);
        send_frame(8'h3C, 2'b00, 0, 1, 0, 0, 1);
        idle_bits(2);
        send_frame(8'h12, 2'b00, 0, 0, 0, 0, 1);
        idle_bits(2);
        send_frame(8'h5A, 2'b10, 0, 0, 1, 0, 1);
        idle_bits(2);
        send_frame(8'hC3, 2'b10, 0, 0, 1, 1, 1);
        idle_bits(2);
        send_frame(8'h96, 2'b01, 0, 0, 0, 0, 1);
        idle_bits(2);

`ifdef UART_RX_BREAK_DET_EN
        push_zero = 1'b0;
`else
        push_zero = 1'b1;
`endif
        send_frame(8'h00, 2'b00, 0, 1, 0, 0, push_zero);
        idle_bits(3);
        wait_drain();

        // Back-to-back frames into a full holding register
        @(posedge clk);
        #1 rx_ready = 1'b0;
        send_frame(8'h11, 2'b00, 0, 0, 0, 0, 1);
        send_frame(8'h22, 2'b00, 0, 0, 0, 0, 0);
        idle_bits(2);
        check("ovr_valid_held", rx_valid, 1);
        check("ovr_data_held", rx_data, 8'h11);
        check("ovr_flag_set", overrun, 1);
        @(posedge clk);
        #1 rx_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("ovr_flag_clear", overrun, 0);
        check("ovr_valid_clear", rx_valid, 0);
        wait_drain();

        // Short low glitch on the idle line
        rx_in = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("glitch_busy_hi", busy, 1);
        repeat (10) @(posedge clk);
        rx_in = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("glitch_busy_lo", busy, 0);
        check("glitch_no_valid", rx_valid, 0);

        // Reset in the middle of the data bits of 0x7E
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        #1;
        check("mid_busy_before", busy, 1);
        reset = 1'b0;
        #1;
        check("mid_rst_data", rx_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", rx_valid, 0);
        rx_in = 1'b1;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        idle_bits(2);
        send_frame(8'h81, 2'b00, 0, 0, 0, 0, 1);
        idle_bits(2);
        wait_drain();

        check("final_busy", busy, 0);
        check("queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
